// File: rtl/food_placement_controller_if.sv
// Bus between the food placement controller and its environment: the
// placement request/result handshake plus the grid store read port.
interface food_placement_controller_if #(
    parameter int GRID_HEIGHT    = 16,
    parameter int GRID_WIDTH     = 16,
    parameter int BITS_PER_BLOCK = 2
);
    localparam int VW = $clog2(GRID_HEIGHT);
    localparam int HW = $clog2(GRID_WIDTH);

    logic                      PlaceReq;
    logic [3:0]                EntropyIn;
    logic                      RdEn;
    logic [VW-1:0]             RdV;
    logic [HW-1:0]             RdH;
    logic [BITS_PER_BLOCK-1:0] RdData;
    logic [VW-1:0]             NextFoodV;
    logic [HW-1:0]             NextFoodH;
    logic                      FoodValid;
    logic                      Busy;
    logic                      Fallback;
    logic                      GridFull;

    // Controller side
    modport master (
        input  PlaceReq, EntropyIn, RdData,
        output RdEn, RdV, RdH, NextFoodV, NextFoodH, FoodValid, Busy, Fallback, GridFull
    );

    // Game logic / grid store side
    modport slave (
        output PlaceReq, EntropyIn, RdData,
        input  RdEn, RdV, RdH, NextFoodV, NextFoodH, FoodValid, Busy, Fallback, GridFull
    );
endinterface

// File: rtl/food_placement_controller.sv
// Food placement controller: draws random interior candidates from an
// entropy-mixed Galois LFSR, checks them against the grid store, and falls
// back to a raster scan when the random tries run out.
module food_placement_controller #(
    parameter int                        GRID_HEIGHT    = 16,
    parameter int                        GRID_WIDTH     = 16,
    parameter int                        BITS_PER_BLOCK = 2,
    parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY    = '0,
    parameter int                        MAX_TRIES      = 64,
    parameter logic [15:0]               LFSR_SEED      = 16'hACE1
) (
    input  logic                         MasterClock,
    input  logic                         Reset,
    food_placement_controller_if.master  placeBus
);
    localparam int          VW        = $clog2(GRID_HEIGHT);
    localparam int          HW        = $clog2(GRID_WIDTH);
    localparam int          TW        = $clog2(MAX_TRIES + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [3:0] {
        IDLE, PICK, READ, CHECK, SCAN_INIT, SCAN_READ, SCAN_CHECK, DONE, FULL
    } state_t;

    state_t        state, stateNext;
    logic [15:0]   lfsr, lfsrShift, lfsrNext;
    logic [TW-1:0] tries, triesNext, triesInc;
    logic [VW-1:0] rdV, rdVNext, nextV, nextVNext, candV;
    logic [HW-1:0] rdH, rdHNext, nextH, nextHNext, candH;
    logic          rdEn, rdEnNext, foodValid, foodValidNext, busy, busyNext;
    logic          fallback, fallbackNext, gridFull, gridFullNext;
    logic          candInterior, triesExhausted, cellEmpty;

    assign candV          = VW'(lfsr[7:4]);
    assign candH          = HW'(lfsr[3:0]);
    assign candInterior   = (candV >= VW'(1)) && (candV <= VW'(GRID_HEIGHT - 2)) &&
                            (candH >= HW'(1)) && (candH <= HW'(GRID_WIDTH - 2));
    assign triesInc       = tries + TW'(1);
    assign triesExhausted = (triesInc == TW'(MAX_TRIES));
    assign cellEmpty      = (placeBus.RdData == BLOCK_EMPTY);

    // LFSR step: Galois shift, button entropy into the low nibble, never all-zero
    always_comb begin
        lfsrShift       = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        lfsrShift[3:0]  = lfsrShift[3:0] ^ placeBus.EntropyIn;
        lfsrNext        = (lfsrShift == '0) ? LFSR_SEED : lfsrShift;
    end

    // Next-state and next-output decode; outputs are registered from stateNext
    always_comb begin
        stateNext    = state;
        triesNext    = tries;
        rdVNext      = rdV;
        rdHNext      = rdH;
        nextVNext    = nextV;
        nextHNext    = nextH;
        fallbackNext = 1'b0;
        case (state)
            IDLE: begin
                if (placeBus.PlaceReq) begin
                    triesNext = '0;
                    stateNext = PICK;
                end
            end
            PICK: begin
                if (candInterior) begin
                    rdVNext   = candV;
                    rdHNext   = candH;
                    stateNext = READ;
                end else begin
                    triesNext = triesInc;
                    stateNext = triesExhausted ? SCAN_INIT : PICK;
                end
            end
            READ: stateNext = CHECK;
            CHECK: begin
                if (cellEmpty) begin
                    nextVNext = rdV;
                    nextHNext = rdH;
                    stateNext = DONE;
                end else begin
                    triesNext = triesInc;
                    stateNext = triesExhausted ? SCAN_INIT : PICK;
                end
            end
            SCAN_INIT: begin
                rdVNext   = VW'(1);
                rdHNext   = HW'(1);
                stateNext = SCAN_READ;
            end
            SCAN_READ: stateNext = SCAN_CHECK;
            SCAN_CHECK: begin
                if (cellEmpty) begin
                    nextVNext    = rdV;
                    nextHNext    = rdH;
                    fallbackNext = 1'b1;
                    stateNext    = DONE;
                end else if (rdH == HW'(GRID_WIDTH - 2)) begin
                    rdHNext = HW'(1);
                    if (rdV == VW'(GRID_HEIGHT - 2)) begin
                        stateNext = FULL;
                    end else begin
                        rdVNext   = rdV + VW'(1);
                        stateNext = SCAN_READ;
                    end
                end else begin
                    rdHNext   = rdH + HW'(1);
                    stateNext = SCAN_READ;
                end
            end
            DONE:    stateNext = IDLE;
            FULL:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // Decoding from stateNext makes each registered pulse coincide with its state
        rdEnNext      = (stateNext == READ) || (stateNext == SCAN_READ);
        foodValidNext = (stateNext == DONE);
        gridFullNext  = (stateNext == FULL);
        busyNext      = (stateNext != IDLE);
    end

    // State, LFSR and registered outputs
    always_ff @(posedge MasterClock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            tries     <= '0;
            rdV       <= '0;
            rdH       <= '0;
            nextV     <= VW'(8);
            nextH     <= HW'(8);
            rdEn      <= 1'b0;
            foodValid <= 1'b0;
            busy      <= 1'b0;
            fallback  <= 1'b0;
            gridFull  <= 1'b0;
        end else begin
            state     <= stateNext;
            lfsr      <= lfsrNext;
            tries     <= triesNext;
            rdV       <= rdVNext;
            rdH       <= rdHNext;
            nextV     <= nextVNext;
            nextH     <= nextHNext;
            rdEn      <= rdEnNext;
            foodValid <= foodValidNext;
            busy      <= busyNext;
            fallback  <= fallbackNext;
            gridFull  <= gridFullNext;
        end
    end

    assign placeBus.RdEn      = rdEn;
    assign placeBus.RdV       = rdV;
    assign placeBus.RdH       = rdH;
    assign placeBus.NextFoodV = nextV;
    assign placeBus.NextFoodH = nextH;
    assign placeBus.FoodValid = foodValid;
    assign placeBus.Busy      = busy;
    assign placeBus.Fallback  = fallback;
    assign placeBus.GridFull  = gridFull;
endmodule

// File: tb/tb_food_placement_controller.sv
// Self-checking bench for food_placement_controller: reset values, random
// placement on an empty grid, single-hole and full-grid scan table, held
// requests, and reset during the raster scan.
module tb_food_placement_controller;
    localparam int GH = 16;
    localparam int GW = 16;

    typedef struct {
        int holeV;
        int holeH;
        bit hasHole;
        int expScanReads;
        int expV;
        int expH;
        bit expFull;
    } vec_t;

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic [1:0]  grid [GH][GW];
    logic [15:0] mdl;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rdCnt    = 0;
    int          foodCnt  = 0;
    int          fullCnt  = 0;

    food_placement_controller_if #(.GRID_HEIGHT(GH), .GRID_WIDTH(GW), .BITS_PER_BLOCK(2)) ifc ();

    food_placement_controller #(
        .GRID_HEIGHT(GH), .GRID_WIDTH(GW), .BITS_PER_BLOCK(2),
        .BLOCK_EMPTY(2'b00), .MAX_TRIES(64), .LFSR_SEED(16'hACE1)
    ) dut (
        .MasterClock(clk),
        .Reset(rstN),
        .placeBus(ifc)
    );

    always #5 clk = ~clk;

    // Cycle and pulse counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstN) begin
            if (ifc.RdEn)      rdCnt   <= rdCnt + 1;
            if (ifc.FoodValid) foodCnt <= foodCnt + 1;
            if (ifc.GridFull)  fullCnt <= fullCnt + 1;
        end
    end

    // Grid store: data for the addressed cell is valid the cycle after RdEn
    always @(posedge clk) begin
        if (ifc.RdEn) ifc.RdData <= grid[ifc.RdV][ifc.RdH];
    end

    function automatic logic [15:0] lfsrStep(input logic [15:0] l, input logic [3:0] e);
        logic [15:0] n;
        n = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        n[3:0] = n[3:0] ^ e;
        if (n == 16'h0000) n = 16'hACE1;
        return n;
    endfunction

    // Reference LFSR stepping on the same edges as the controller
    always @(posedge clk or negedge rstN) begin
        if (!rstN) mdl <= 16'hACE1;
        else       mdl <= lfsrStep(mdl, ifc.EntropyIn);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fillGrid(input bit allEmpty, input bit hasHole, input int hv, input int hh);
        for (int v = 0; v < GH; v++)
            for (int h = 0; h < GW; h++) begin
                if (v == 0 || v == GH-1 || h == 0 || h == GW-1) grid[v][h] = 2'b01;
                else if (allEmpty)                              grid[v][h] = 2'b00;
                else                                            grid[v][h] = 2'b10;
            end
        if (hasHole) grid[hv][hh] = 2'b00;
    endtask

    // Walk the random phase from the first PICK candidate
    task automatic predict(input logic [15:0] l0, input logic [3:0] ent, input bit allEmpty,
                           input bit hasHole, input int hv, input int hh,
                           output bit hit, output int reads, output int lat,
                           output int pv, output int ph);
        logic [15:0] l;
        int tries, t, v, h;
        l = l0; tries = 0; t = 0;
        hit = 0; reads = 0; lat = 0; pv = 0; ph = 0;
        while (tries < 64) begin
            v = int'(l[7:4]);
            h = int'(l[3:0]);
            if (v >= 1 && v <= GH-2 && h >= 1 && h <= GW-2) begin
                reads++;
                if (allEmpty || (hasHole && v == hv && h == hh)) begin
                    hit = 1; lat = t + 4; pv = v; ph = h;
                    break;
                end
                t += 3;
                l = lfsrStep(lfsrStep(lfsrStep(l, ent), ent), ent);
            end else begin
                t += 1;
                l = lfsrStep(l, ent);
            end
            tries++;
        end
    endtask

    // One request pulse; checks result, read count, latency and Busy drop
    task automatic runCase(input string tag, input bit allEmpty, input bit hasHole,
                           input int hv, input int hh, input int expScanReads,
                           input bit expFull, input int expV, input int expH);
        int c0, f0, g0, r0, preds, plat, pv, ph, eV, eH;
        bit hit, seen;
        @(posedge clk); #1;
        ifc.PlaceReq = 1'b1;
        c0 = cyc; f0 = foodCnt; g0 = fullCnt; r0 = rdCnt;
        @(posedge clk); #1;
        ifc.PlaceReq = 1'b0;
        predict(mdl, ifc.EntropyIn, allEmpty, hasHole, hv, hh, hit, preds, plat, pv, ph);
        seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ifc.FoodValid || ifc.GridFull) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        chk({tag, " finished"}, int'(seen), 1);
        if (seen) begin
            eV = hit ? pv : expV;
            eH = hit ? ph : expH;
            chk({tag, " GridFull"},  int'(ifc.GridFull),  int'(expFull));
            chk({tag, " FoodValid"}, int'(ifc.FoodValid), int'(!expFull));
            chk({tag, " Busy in final state"}, int'(ifc.Busy), 1);
            chk({tag, " NextFoodV"}, int'(ifc.NextFoodV), eV);
            chk({tag, " NextFoodH"}, int'(ifc.NextFoodH), eH);
            if (!expFull) chk({tag, " Fallback"}, int'(ifc.Fallback), int'(!hit));
            chk({tag, " reads"}, rdCnt - r0, preds + (hit ? 0 : expScanReads));
            if (hit) chk({tag, " latency"}, cyc - c0, plat);
            @(posedge clk); #1;
            chk({tag, " Busy after"},      int'(ifc.Busy), 0);
            chk({tag, " pulse one cycle"}, int'(ifc.FoodValid | ifc.GridFull | ifc.Fallback), 0);
            chk({tag, " FoodValid count"}, foodCnt - f0, expFull ? 0 : 1);
            chk({tag, " GridFull count"},  fullCnt - g0, expFull ? 1 : 0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int n, r0, f0, g0;
        bit found;

        vecs[0] = '{holeV: 5,  holeH: 9,  hasHole: 1, expScanReads: 65,  expV: 5,  expH: 9,  expFull: 0};
        vecs[1] = '{holeV: 1,  holeH: 1,  hasHole: 1, expScanReads: 1,   expV: 1,  expH: 1,  expFull: 0};
        vecs[2] = '{holeV: 1,  holeH: 14, hasHole: 1, expScanReads: 14,  expV: 1,  expH: 14, expFull: 0};
        vecs[3] = '{holeV: 14, holeH: 1,  hasHole: 1, expScanReads: 183, expV: 14, expH: 1,  expFull: 0};
        vecs[4] = '{holeV: 14, holeH: 14, hasHole: 1, expScanReads: 196, expV: 14, expH: 14, expFull: 0};
        vecs[5] = '{holeV: 0,  holeH: 0,  hasHole: 0, expScanReads: 196, expV: 14, expH: 14, expFull: 1};

        ifc.PlaceReq  = 1'b0;
        ifc.EntropyIn = 4'h0;
        fillGrid(1, 0, 0, 0);

        // Power-up reset values
        #20;
        chk("rst NextFoodV", int'(ifc.NextFoodV), 8);
        chk("rst NextFoodH", int'(ifc.NextFoodH), 8);
        chk("rst RdEn",      int'(ifc.RdEn), 0);
        chk("rst Busy",      int'(ifc.Busy), 0);
        chk("rst pulses",    int'(ifc.FoodValid | ifc.Fallback | ifc.GridFull), 0);
        chk("rst lfsr",      int'(dut.lfsr), 16'hACE1);
        #2 rstN = 1'b1;

        // Empty grid, random placement
        runCase("empty e0", 1, 0, 0, 0, 1, 0, 1, 1);
        ifc.EntropyIn = 4'h5;
        runCase("empty e5", 1, 0, 0, 0, 1, 0, 1, 1);
        ifc.EntropyIn = 4'h0;

        // PlaceReq held across three placements
        @(posedge clk); #1;
        f0 = foodCnt;
        ifc.PlaceReq = 1'b1;
        n = 0;
        for (int i = 0; i < 600 && n < 3; i++) begin
            @(posedge clk); #1;
            if (ifc.FoodValid) begin
                n++;
                if (n == 3) ifc.PlaceReq = 1'b0;
                @(posedge clk); #1;
                chk("held IDLE gap Busy", int'(ifc.Busy), 0);
            end
        end
        ifc.PlaceReq = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("held pulses seen", n, 3);
        chk("held FoodValid count", foodCnt - f0, 3);
        chk("held idle afterwards", int'(ifc.Busy), 0);

        // Single-hole and full-grid table
        for (int i = 0; i < 6; i++) begin
            fillGrid(0, vecs[i].hasHole, vecs[i].holeV, vecs[i].holeH);
            runCase($sformatf("vec%0d", i), 0, vecs[i].hasHole, vecs[i].holeV, vecs[i].holeH,
                    vecs[i].expScanReads, vecs[i].expFull, vecs[i].expV, vecs[i].expH);
        end

        // Reset during SCAN_CHECK on a full grid
        fillGrid(0, 0, 0, 0);
        @(posedge clk); #1;
        ifc.PlaceReq = 1'b1;
        r0 = rdCnt; f0 = foodCnt; g0 = fullCnt;
        @(posedge clk); #1;
        ifc.PlaceReq = 1'b0;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rdCnt - r0 >= 70 && !ifc.RdEn && ifc.Busy) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("midrst reached scan", int'(found), 1);
        #2 rstN = 1'b0;
        #1;
        chk("midrst NextFoodV", int'(ifc.NextFoodV), 8);
        chk("midrst NextFoodH", int'(ifc.NextFoodH), 8);
        chk("midrst RdEn",      int'(ifc.RdEn), 0);
        chk("midrst Busy",      int'(ifc.Busy), 0);
        chk("midrst pulses",    int'(ifc.FoodValid | ifc.Fallback | ifc.GridFull), 0);
        chk("midrst lfsr",      int'(dut.lfsr), 16'hACE1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst held lfsr", int'(dut.lfsr), 16'hACE1);
        rstN = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst no FoodValid", foodCnt - f0, 0);
        chk("midrst no GridFull",  fullCnt - g0, 0);
        chk("midrst idle",         int'(ifc.Busy), 0);
        fillGrid(1, 0, 0, 0);
        runCase("after reset", 1, 0, 0, 0, 1, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
